// File: rtl/br_recovery_ctrl.sv
// Branch-mispredict recovery sequencer: flushes the front end, walks squashed
// ROB entries youngest-first for rename rollback, then redirects the PC.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no recovery; a front-end jump may flush IF this cycle
// FLUSH    | one cycle, flush IF/ID/IQ
// WALK     | present squashed entries youngest-first to the rename table
// REDIRECT | one cycle, load the PC and reset the ROB tail
module br_recovery_ctrl #(
    parameter int ROB_DEPTH = 16,
    parameter int PTR_W     = 4,
    parameter int PC_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_mispredict,
    input  logic [PC_W-1:0]  br_target_pc,
    input  logic [PTR_W-1:0] rob_head_idx,
    input  logic [PTR_W:0]   rob_count,
    input  logic             jp_taken,
    input  logic             walk_ready,
    output logic             busy,
    output logic             if_flush,
    output logic             id_flush,
    output logic             iq_flush,
    output logic             walk_valid,
    output logic [PTR_W-1:0] walk_rob_idx,
    output logic             pc_redirect_valid,
    output logic [PC_W-1:0]  pc_redirect,
    output logic             rob_reset_tail
);

    typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_WALK, S_REDIRECT} state_t;

    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    state_t           state, state_nxt;
    logic [PTR_W:0]   walk_cnt;
    logic [PTR_W-1:0] walk_ptr;
    logic [PC_W-1:0]  target_q;
    logic [PTR_W-1:0] youngest_idx;

    // Truncation to PTR_W bits is the mod-ROB_DEPTH wrap; count==ROB_DEPTH folds to 0.
    assign youngest_idx = rob_head_idx + rob_count[PTR_W-1:0] - PTR_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            walk_cnt <= '0;
            walk_ptr <= '0;
            target_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && br_mispredict) begin
                target_q <= br_target_pc;
                walk_cnt <= rob_count - CNT_ONE;
                walk_ptr <= youngest_idx;
            end else if (state == S_WALK && walk_ready) begin
                walk_cnt <= walk_cnt - CNT_ONE;
                walk_ptr <= walk_ptr - PTR_ONE;
            end
        end
    end

    always_comb begin
        state_nxt         = state;
        busy              = 1'b0;
        if_flush          = 1'b0;
        id_flush          = 1'b0;
        iq_flush          = 1'b0;
        walk_valid        = 1'b0;
        walk_rob_idx      = '0;
        pc_redirect_valid = 1'b0;
        pc_redirect       = '0;
        rob_reset_tail    = 1'b0;
        case (state)
            S_IDLE: begin
                if_flush = jp_taken;
                if (br_mispredict) state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                busy      = 1'b1;
                if_flush  = 1'b1;
                id_flush  = 1'b1;
                iq_flush  = 1'b1;
                state_nxt = (walk_cnt != '0) ? S_WALK : S_REDIRECT;
            end
            S_WALK: begin
                busy         = 1'b1;
                walk_valid   = 1'b1;
                walk_rob_idx = walk_ptr;
                if (walk_ready && walk_cnt == CNT_ONE) state_nxt = S_REDIRECT;
            end
            S_REDIRECT: begin
                busy              = 1'b1;
                pc_redirect_valid = 1'b1;
                pc_redirect       = target_q;
                rob_reset_tail    = 1'b1;
                state_nxt         = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: doc/br_recovery_ctrl.md
Name: br_recovery_ctrl

Overview:
- Sequences pipeline recovery after a branch mispredict is detected at ROB commit.
- Flushes the front end and issue queue.
- Walks the squashed ROB entries youngest-first so the rename map can roll back, then redirects the PC and resets the ROB tail.
- Sits between the ROB commit port, the rename table and the top-level stall/flush control.
- Also turns front-end jump redirects into a single-cycle IF flush.

Parameters:
- ROB_DEPTH, 16, number of ROB entries; power of two, at least 2.
- PTR_W, 4, log2(ROB_DEPTH); width of a ROB index.
- PC_W, 32, program counter width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- br_mispredict  in  1  the committing ROB head is a mispredicted branch; sampled only in IDLE.
- br_target_pc  in  PC_W  correct target; valid with br_mispredict.
- rob_head_idx  in  PTR_W  index of the committing (mispredicted) entry.
- rob_count  in  PTR_W+1  valid ROB entries, including the head; range 1..ROB_DEPTH when br_mispredict is high.
- jp_taken  in  1  front-end jump redirect.
- walk_ready  in  1  rename table accepts one rollback entry this cycle.
- busy  out  1  recovery in progress; also used as commit stall and frontend hold.
- if_flush  out  1  flush the IF stage.
- id_flush  out  1  flush the ID stage.
- iq_flush  out  1  flush the issue queue.
- walk_valid  out  1  walk_rob_idx is valid for rollback.
- walk_rob_idx  out  PTR_W  ROB entry to roll back.
- pc_redirect_valid  out  1  load pc_redirect into the PC.
- pc_redirect  out  PC_W  redirect target.
- rob_reset_tail  out  1  set the ROB tail to head+1 and count to 0 (after the head retires).

Behaviour:
- Reset: state IDLE; every output 0, including walk_rob_idx and pc_redirect; internal counter and latches 0. Reset asserted in any state aborts the sequence immediately, with no partial redirect.
- FSM states: IDLE, FLUSH, WALK, REDIRECT. Outputs are decoded from registered state, except the jump flush described under IDLE.
- IDLE, busy=0:
  - br_mispredict=1: latch br_target_pc; latch walk_cnt = rob_count-1 (PTR_W+1 bits); latch walk_ptr = (rob_head_idx + rob_count - 1) mod ROB_DEPTH, which is the youngest entry. Go to FLUSH.
  - if_flush = jp_taken, combinational, IDLE only.
  - br_mispredict takes precedence over jp_taken in the same cycle; if_flush still follows jp_taken that cycle.
- FLUSH, exactly 1 cycle:
  - if_flush=id_flush=iq_flush=1; busy=1.
  - Next state: WALK if walk_cnt != 0, else REDIRECT.
- WALK:
  - busy=1; walk_valid=1; walk_rob_idx=walk_ptr.
  - On walk_valid && walk_ready: walk_ptr decrements mod ROB_DEPTH (wraps 0 -> ROB_DEPTH-1); walk_cnt decrements.
  - When the accepted walk is the last one (walk_cnt==1), go to REDIRECT.
  - walk_ready=0 holds walk_valid and walk_rob_idx stable.
  - The head entry itself is never walked.
- REDIRECT, exactly 1 cycle:
  - busy=1; pc_redirect_valid=1; pc_redirect = latched target; rob_reset_tail=1.
  - Next state: IDLE.
- While busy, br_mispredict and jp_taken are ignored, and if_flush follows the FSM only.
- Latency: br_mispredict sampled at edge E gives FLUSH in cycle E+1, the first walk in E+2, REDIRECT in E+2+N (N = rob_count-1, walk_ready always 1), and IDLE in E+3+N.
- Back-to-back: a mispredict sampled in the cycle the FSM returns to IDLE starts a new sequence with no bubble.
- rob_count==ROB_DEPTH gives walk_cnt = ROB_DEPTH-1; the counter is PTR_W+1 bits, so it does not overflow.

Test Plan:
- Reset check: assert rst mid-WALK -> all outputs 0 asynchronously, with no pc_redirect_valid. Release rst -> IDLE.
- Basic walk:
  - Stimulus: br_mispredict with head=3, count=4, target=0x0000_1000, walk_ready=1.
  - Flush outputs high for 1 cycle.
  - walk_rob_idx = 6, 5, 4 on consecutive cycles.
  - Then pc_redirect_valid=1 with pc_redirect=0x1000 and rob_reset_tail=1.
  - busy high for exactly 5 cycles.
- Wrap and backpressure:
  - Stimulus: head=14, count=5, walk_ready toggling 1,0,1,0,...
  - walk_rob_idx sequence is 2, 1, 0, 15, each value held across each ready=0 cycle.
  - REDIRECT follows the 4th accepted walk.
- No walk: count=1 -> FLUSH immediately followed by REDIRECT, walk_valid never high, busy for 2 cycles.
- Full ROB: head=0, count=16 -> 15 walks, 15 down to 1, and no entry 0 walk.
- Jump and collisions:
  - jp_taken in IDLE -> if_flush high the same cycle only, busy stays 0.
  - jp_taken or br_mispredict during WALK -> ignored, sequence unchanged.
  - br_mispredict with jp_taken together -> recovery starts.
